// File: rtl/ibex_mem_arbiter.sv
// Two-to-one arbiter that lets the Ibex fetch and load/store ports share one memory bus.
// It holds a stalled address phase until grant and routes responses back in issue order.
module ibex_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          DATA_PRIORITY   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  logic            lock_q, lock_d;
  port_e           lock_sel_q, lock_sel_d;
  port_e           last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  port_e           id_q [MAX_OUTSTANDING];

  port_e sel;
  port_e head;
  logic  sel_req;
  logic  full;
  logic  push;
  logic  pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel = PORT_INSTR;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (instr_req_i && data_req_i) begin
      if (DATA_PRIORITY) begin
        sel = PORT_DATA;
      end else begin
        sel = (last_q == PORT_DATA) ? PORT_INSTR : PORT_DATA;
      end
    end else if (data_req_i) begin
      sel = PORT_DATA;
    end
  end

  // Full blocks new requests even when a response frees a slot in the same cycle.
  assign full      = (cnt_q >= CntW'(MAX_OUTSTANDING));
  assign sel_req   = (sel == PORT_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o = sel_req & ~full;

  assign mem_we_o    = (sel == PORT_DATA) ? data_we_i    : 1'b0;
  assign mem_be_o    = (sel == PORT_DATA) ? data_be_i    : 4'hF;
  assign mem_addr_o  = (sel == PORT_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = (sel == PORT_DATA) ? data_wdata_i : 32'h0;

  assign push = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = push & (sel == PORT_INSTR);
  assign data_gnt_o  = push & (sel == PORT_DATA);

  // A response with nothing outstanding is a bus protocol violation and is dropped.
  assign pop  = mem_rvalid_i & (cnt_q != '0);
  assign head = id_q[rd_ptr_q];

  assign instr_rvalid_o = pop & (head == PORT_INSTR);
  assign data_rvalid_o  = pop & (head == PORT_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;

  always_comb begin
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    last_d     = last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    if (push) begin
      lock_d   = 1'b0;
      last_d   = sel;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else if (mem_req_o) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_sel_q <= PORT_INSTR;
      last_q     <= PORT_DATA;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: the ID storage is not reset; an entry is only read after it was written, as guarded by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Bench for ibex_mem_arbiter: instance 0 uses data priority, instance 1 round-robin.
// Directed scenarios plus randomized traffic compared against a queue-based reference model.
module tb_ibex_mem_arbiter;

  localparam int MAXO = 2;
  localparam int VW   = 140;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [1:0]       ireq, dreq, dwe, mgnt, mrv, merr;
  logic [1:0][31:0] iaddr, daddr, dwdata, mrdata;
  logic [1:0][3:0]  dbe;
  logic [1:0]       igrant, irv, ierr, dgnt, drv, derr, mreq, mwe;
  logic [1:0][31:0] irdata, drdata, maddr, mwdata;
  logic [1:0][3:0]  mbe;

  int errors = 0;
  int checks = 0;

  // Reference model state: queue of issuing ports (1 = data) in grant order.
  bit m_q[$];
  bit m_locked;
  bit m_owner;
  bit m_last;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ibex_mem_arbiter #(
      .MAX_OUTSTANDING(MAXO),
      .DATA_PRIORITY  ((g == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .instr_req_i   (ireq[g]),
      .instr_gnt_o   (igrant[g]),
      .instr_rvalid_o(irv[g]),
      .instr_addr_i  (iaddr[g]),
      .instr_rdata_o (irdata[g]),
      .instr_err_o   (ierr[g]),
      .data_req_i    (dreq[g]),
      .data_gnt_o    (dgnt[g]),
      .data_rvalid_o (drv[g]),
      .data_we_i     (dwe[g]),
      .data_be_i     (dbe[g]),
      .data_addr_i   (daddr[g]),
      .data_wdata_i  (dwdata[g]),
      .data_rdata_o  (drdata[g]),
      .data_err_o    (derr[g]),
      .mem_req_o     (mreq[g]),
      .mem_gnt_i     (mgnt[g]),
      .mem_rvalid_i  (mrv[g]),
      .mem_we_o      (mwe[g]),
      .mem_be_o      (mbe[g]),
      .mem_addr_o    (maddr[g]),
      .mem_wdata_o   (mwdata[g]),
      .mem_rdata_i   (mrdata[g]),
      .mem_err_i     (merr[g])
    );
  end

  function automatic logic [VW-1:0] act_vec(input int d);
    return {mreq[d], mwe[d], mbe[d], maddr[d], mwdata[d], igrant[d], dgnt[d],
            irv[d], drv[d], irdata[d], ierr[d], drdata[d], derr[d]};
  endfunction

  task automatic clr_inputs();
    ireq = '0; dreq = '0; dwe = '0; mgnt = '0; mrv = '0; merr = '0;
    iaddr = '0; daddr = '0; dwdata = '0; mrdata = '0; dbe = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [VW-1:0] obs, exp;
    rst_ni = 1'b0;
    clr_inputs();
    #2;
    exp = {1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0};
    for (int d = 0; d < 2; d++) begin
      obs = act_vec(d);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_in dut%0d got=%h want=%h", d, obs, exp);
      end
    end
    do_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      obs = act_vec(d);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_idle dut%0d got=%h want=%h", d, obs, exp);
      end
    end
  endtask

  task automatic test_lock();
    logic [VW-1:0] obs, exp;
    do_reset();
    ireq[0] = 1'b1; iaddr[0] = 32'h100; mgnt[0] = 1'b0;
    #2;
    obs = VW'({mreq[0], igrant[0], dgnt[0], maddr[0]});
    exp = VW'({3'b100, 32'h100});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lock_c0 got=%h want=%h", obs, exp); end
    tick();
    dreq[0] = 1'b1; daddr[0] = 32'h2000;
    #2;
    obs = VW'({mreq[0], igrant[0], dgnt[0], maddr[0]});
    exp = VW'({3'b100, 32'h100});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lock_c1 got=%h want=%h", obs, exp); end
    tick();
    mgnt[0] = 1'b1;
    #2;
    obs = VW'({mreq[0], igrant[0], dgnt[0], maddr[0]});
    exp = VW'({3'b110, 32'h100});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lock_c2 got=%h want=%h", obs, exp); end
    tick();
    ireq[0] = 1'b0;
    #2;
    obs = VW'({mreq[0], igrant[0], dgnt[0], maddr[0]});
    exp = VW'({3'b101, 32'h2000});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lock_c3 got=%h want=%h", obs, exp); end
    tick();
    dreq[0] = 1'b0; mgnt[0] = 1'b0; mrv[0] = 1'b1; mrdata[0] = 32'h11;
    #2;
    obs = VW'({irv[0], drv[0], irdata[0]});
    exp = VW'({2'b10, 32'h11});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lock_rsp0 got=%h want=%h", obs, exp); end
    tick();
    mrdata[0] = 32'h22;
    #2;
    obs = VW'({irv[0], drv[0], drdata[0]});
    exp = VW'({2'b01, 32'h22});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lock_rsp1 got=%h want=%h", obs, exp); end
    tick();
    clr_inputs();
  endtask

  task automatic test_round_robin();
    logic [VW-1:0] obs, exp;
    bit to_data, prev_data;
    do_reset();
    ireq[1] = 1'b1; dreq[1] = 1'b1; iaddr[1] = 32'h1000; daddr[1] = 32'h3000;
    mgnt[1] = 1'b1; mrv[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mrdata[1] = 32'h5000 + k;
      to_data   = k[0];
      prev_data = ~k[0];
      #2;
      obs = VW'({igrant[1], dgnt[1], maddr[1]});
      exp = VW'({~to_data, to_data, to_data ? 32'h3000 : 32'h1000});
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rr_gnt k=%0d got=%h want=%h", k, obs, exp); end
      obs = VW'({irv[1], drv[1], irdata[1], drdata[1]});
      if (k == 0) exp = VW'({2'b00, mrdata[1], mrdata[1]});
      else        exp = VW'({~prev_data, prev_data, mrdata[1], mrdata[1]});
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rr_rsp k=%0d got=%h want=%h", k, obs, exp); end
      tick();
    end
    clr_inputs();
  endtask

  task automatic test_ordering();
    logic [VW-1:0] obs, exp;
    do_reset();
    ireq[0] = 1'b1; iaddr[0] = 32'h0; mgnt[0] = 1'b1;
    #2;
    obs = VW'({igrant[0], dgnt[0]});
    exp = VW'(2'b10);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ord_gnt_i got=%h want=%h", obs, exp); end
    tick();
    ireq[0] = 1'b0; dreq[0] = 1'b1; daddr[0] = 32'h2000; dwe[0] = 1'b0; dbe[0] = 4'hF;
    #2;
    obs = VW'({igrant[0], dgnt[0], maddr[0], mwe[0]});
    exp = VW'({2'b01, 32'h2000, 1'b0});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ord_gnt_d got=%h want=%h", obs, exp); end
    tick();
    dreq[0] = 1'b0; mgnt[0] = 1'b0; mrv[0] = 1'b1; mrdata[0] = 32'hAAAA0000;
    #2;
    obs = VW'({irv[0], drv[0], irdata[0]});
    exp = VW'({2'b10, 32'hAAAA0000});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ord_rsp_i got=%h want=%h", obs, exp); end
    tick();
    mrdata[0] = 32'hBBBB0000;
    #2;
    obs = VW'({irv[0], drv[0], drdata[0]});
    exp = VW'({2'b01, 32'hBBBB0000});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ord_rsp_d got=%h want=%h", obs, exp); end
    tick();
    mrv[0] = 1'b0;
    #2;
    obs = VW'({irv[0], drv[0]});
    exp = VW'(2'b00);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ord_quiet got=%h want=%h", obs, exp); end
    tick();
    clr_inputs();
  endtask

  task automatic test_full();
    logic [VW-1:0] obs, exp;
    do_reset();
    ireq[0] = 1'b1; mgnt[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iaddr[0] = 32'h40 + 32'(4 * k);
      #2;
      obs = VW'({mreq[0], igrant[0]});
      exp = VW'(2'b11);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL full_fill k=%0d got=%h want=%h", k, obs, exp); end
      tick();
    end
    iaddr[0] = 32'h48;
    for (int k = 0; k < 2; k++) begin
      #2;
      obs = VW'({mreq[0], igrant[0]});
      exp = VW'(2'b00);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL full_block k=%0d got=%h want=%h", k, obs, exp); end
      tick();
    end
    mrv[0] = 1'b1;
    #2;
    obs = VW'({mreq[0], igrant[0], irv[0]});
    exp = VW'(3'b001);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL full_pop got=%h want=%h", obs, exp); end
    tick();
    mrv[0] = 1'b0;
    #2;
    obs = VW'({mreq[0], igrant[0], maddr[0]});
    exp = VW'({2'b11, 32'h48});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL full_resume got=%h want=%h", obs, exp); end
    tick();
    ireq[0] = 1'b0; mgnt[0] = 1'b0; mrv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      obs = VW'({irv[0], drv[0]});
      exp = VW'((k < 2) ? 2'b10 : 2'b00);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL full_drain k=%0d got=%h want=%h", k, obs, exp); end
      tick();
    end
    clr_inputs();
  endtask

  task automatic test_err_spurious();
    logic [VW-1:0] obs, exp;
    do_reset();
    dreq[0] = 1'b1; dwe[0] = 1'b1; dbe[0] = 4'b0011; daddr[0] = 32'h80;
    dwdata[0] = 32'hDEADBEEF; mgnt[0] = 1'b1;
    #2;
    obs = VW'({mreq[0], mwe[0], mbe[0], maddr[0], mwdata[0], dgnt[0], igrant[0]});
    exp = VW'({1'b1, 1'b1, 4'b0011, 32'h80, 32'hDEADBEEF, 1'b1, 1'b0});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL err_wr got=%h want=%h", obs, exp); end
    tick();
    dreq[0] = 1'b0; mgnt[0] = 1'b0;
    tick();
    mrv[0] = 1'b1; merr[0] = 1'b1;
    #2;
    obs = VW'({drv[0], irv[0], derr[0], ierr[0]});
    exp = VW'(4'b1011);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL err_rsp got=%h want=%h", obs, exp); end
    tick();
    merr[0] = 1'b0;
    #2;
    obs = VW'({drv[0], irv[0]});
    exp = VW'(2'b00);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL spurious got=%h want=%h", obs, exp); end
    tick();
    mrv[0] = 1'b0; ireq[0] = 1'b1; iaddr[0] = 32'h10; mgnt[0] = 1'b1;
    #2;
    obs = VW'({mreq[0], igrant[0]});
    exp = VW'(2'b11);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL spur_after_gnt got=%h want=%h", obs, exp); end
    tick();
    ireq[0] = 1'b0; mgnt[0] = 1'b0; mrv[0] = 1'b1;
    #2;
    obs = VW'({irv[0], drv[0]});
    exp = VW'(2'b10);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL spur_after_rsp got=%h want=%h", obs, exp); end
    tick();
    clr_inputs();
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] obs, exp;
    do_reset();
    ireq[0] = 1'b1; iaddr[0] = 32'h200; mgnt[0] = 1'b1;
    #2;
    obs = VW'({igrant[0]});
    exp = VW'(1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL arst_gnt got=%h want=%h", obs, exp); end
    tick();
    ireq[0] = 1'b0; dreq[0] = 1'b1; daddr[0] = 32'h300; mgnt[0] = 1'b0;
    #2;
    obs = VW'({mreq[0], dgnt[0], maddr[0]});
    exp = VW'({2'b10, 32'h300});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL arst_lock got=%h want=%h", obs, exp); end
    tick();
    #2;
    rst_ni = 1'b0;
    dreq[0] = 1'b0; ireq[0] = 1'b1; iaddr[0] = 32'h400; mrv[0] = 1'b1;
    #1;
    obs = VW'({mreq[0], maddr[0], irv[0], drv[0]});
    exp = VW'({1'b1, 32'h400, 2'b00});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL arst_clear got=%h want=%h", obs, exp); end
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1; mrv[0] = 1'b0; mgnt[0] = 1'b1;
    #1;
    obs = VW'({mreq[0], igrant[0], maddr[0]});
    exp = VW'({2'b11, 32'h400});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL arst_regnt got=%h want=%h", obs, exp); end
    tick();
    ireq[0] = 1'b0; mgnt[0] = 1'b0; mrv[0] = 1'b1; mrdata[0] = 32'h7777;
    #2;
    obs = VW'({irv[0], drv[0], irdata[0]});
    exp = VW'({2'b10, 32'h7777});
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL arst_rsp got=%h want=%h", obs, exp); end
    tick();
    clr_inputs();
  endtask

  task automatic test_random(input int d, input int n);
    logic [VW-1:0] obs, exp;
    bit ipend, dpend, sel, e_req, hs, e_pop, head;
    do_reset();
    m_q.delete();
    m_locked = 1'b0; m_owner = 1'b0; m_last = 1'b1;
    ipend = 1'b0; dpend = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (!ipend && $urandom_range(0, 9) < 5) begin
        ipend = 1'b1;
        iaddr[d] = $urandom & 32'hFFFF_FFFC;
      end
      if (!dpend && $urandom_range(0, 9) < 5) begin
        dpend = 1'b1;
        daddr[d]  = $urandom;
        dwe[d]    = 1'($urandom_range(0, 1));
        dbe[d]    = 4'($urandom_range(0, 15));
        dwdata[d] = $urandom;
      end
      ireq[d]   = ipend;
      dreq[d]   = dpend;
      mgnt[d]   = ($urandom_range(0, 9) < 6);
      mrv[d]    = ($urandom_range(0, 9) < 4);
      mrdata[d] = $urandom;
      merr[d]   = ($urandom_range(0, 7) == 0);
      #2;
      if (m_locked)          sel = m_owner;
      else if (ipend && dpend) sel = (d == 0) ? 1'b1 : !m_last;
      else                   sel = dpend;
      e_req = (sel ? dpend : ipend) && (m_q.size() < MAXO);
      hs    = e_req && mgnt[d];
      e_pop = mrv[d] && (m_q.size() > 0);
      head  = e_pop ? m_q[0] : 1'b0;
      exp = {e_req, sel ? dwe[d] : 1'b0, sel ? dbe[d] : 4'hF,
             sel ? daddr[d] : iaddr[d], sel ? dwdata[d] : 32'h0,
             hs && !sel, hs && sel, e_pop && !head, e_pop && head,
             mrdata[d], merr[d], mrdata[d], merr[d]};
      obs = act_vec(d);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random dut%0d cyc=%0d got=%h want=%h", d, c, obs, exp);
      end
      if (e_pop) void'(m_q.pop_front());
      if (hs) begin
        m_q.push_back(sel);
        m_last   = sel;
        m_locked = 1'b0;
        if (sel) dpend = 1'b0;
        else     ipend = 1'b0;
      end else if (e_req) begin
        m_locked = 1'b1;
        m_owner  = sel;
      end
      tick();
    end
    clr_inputs();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_round_robin();
    test_ordering();
    test_full();
    test_err_spurious();
    test_async_reset();
    test_random(0, 400);
    test_random(1, 400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
